core_boot_sequencer: RTL and testbench

- Hardware replacement for the bench-driven core boot flow.
- Phase 1: streams a data image into data memory as word stores while it owns the memory port.
- Phase 2: streams the instruction and register images to one core as network packets, sends the barrier mask and the start PC, then idles the network and hands data memory to the core.
- Sits between the image ROMs, the data_mem port mux, and the core's network input.

---
 rtl/core_boot_sequencer_pkg.sv | 42 ++++
 rtl/core_boot_sequencer_addr_counter.sv | 27 ++
 rtl/core_boot_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_core_boot_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_boot_sequencer_pkg.sv
// rtl/core_boot_sequencer_pkg.sv - shared types for the core boot sequencer
package core_boot_sequencer_pkg;

  typedef enum logic [2:0] {
    NET_OP_NULL  = 3'd0,
    NET_OP_INSTR = 3'd1,
    NET_OP_REG   = 3'd2,
    NET_OP_BAR   = 3'd3,
    NET_OP_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;
    net_op_e     net_op;
    logic [3:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [5:0] rs_imm;
  } instruction_s;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DMEM_RD, ST_DMEM_WR, ST_IMEM, ST_REGS, ST_BAR, ST_PC, ST_NULLP, ST_DONE
  } boot_state_e;

  localparam logic [31:0] NULL_PACKET_DATA = 32'hFFFF_FFFE;

  // Index width wide enough for the longest phase, never below one bit.
  function automatic int unsigned idx_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/core_boot_sequencer_addr_counter.sv
// rtl/core_boot_sequencer_addr_counter.sv - loadable index counter with terminal flag
module boot_addr_counter #(
  parameter int unsigned width_p = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  input  logic [width_p-1:0] last_value,
  output logic [width_p-1:0] idx,
  output logic               last
);

  // Index restarts on clear, otherwise steps when the phase consumes a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == last_value);

endmodule

// File: rtl/core_boot_sequencer.sv
// rtl/core_boot_sequencer.sv - boots one core: data stores, then network packet stream
module core_boot_sequencer
  import core_boot_sequencer_pkg::*;
#(
  parameter int unsigned dmem_words_p = 1024,
  parameter int unsigned imem_words_p = 1024,
  parameter int unsigned reg_words_p  = 64,
  parameter logic [9:0]  core_id_p    = 10'b1,
  parameter logic [31:0] bar_mask_p   = 32'h2,
  parameter logic [9:0]  bar_addr_p   = 10'd24,
  parameter logic [31:0] start_pc_p   = 32'h0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_i,
  output logic [9:0]                      img_addr_o,
  input  logic [15:0]                     instr_data_i,
  input  logic [31:0]                     data_data_i,
  input  logic [39:0]                     reg_data_i,
  output logic                            mem_valid_o,
  output logic                            mem_wen_o,
  output logic [31:0]                     mem_addr_o,
  output logic [31:0]                     mem_wdata_o,
  output logic                            mem_select_o,
  output logic [$bits(net_packet_s)-1:0]  net_packet_flat_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned IDX_W = idx_width(dmem_words_p, imem_words_p, reg_words_p);

  localparam logic [IDX_W-1:0] DMEM_LAST = (dmem_words_p == 0) ? '0 : IDX_W'(dmem_words_p - 1);
  localparam logic [IDX_W-1:0] IMEM_LAST = (imem_words_p == 0) ? '0 : IDX_W'(imem_words_p - 1);
  localparam logic [IDX_W-1:0] REG_LAST  = (reg_words_p == 0)  ? '0 : IDX_W'(reg_words_p - 1);

  // Empty phases are skipped entirely.
  localparam boot_state_e AFTER_IMEM  = (reg_words_p != 0) ? ST_REGS : ST_BAR;
  localparam boot_state_e AFTER_DMEM  = (imem_words_p != 0) ? ST_IMEM : AFTER_IMEM;
  localparam boot_state_e FIRST_STATE = (dmem_words_p != 0) ? ST_DMEM_RD : AFTER_DMEM;

  boot_state_e      state, state_next;
  logic             idx_clear, idx_inc, idx_last;
  logic [IDX_W-1:0] idx, last_value;
  logic             issue_valid;
  net_op_e          issue_op;
  logic             pend_valid;
  net_op_e          pend_op;
  logic [IDX_W-1:0] pend_addr;
  net_packet_s      pkt_q, pkt_next;
  logic             done_q;
  instruction_s     instr_word;
  logic             unused_reg_bits;

  assign instr_word      = instruction_s'(instr_data_i);
  assign unused_reg_bits = ^reg_data_i[39:38];

  // Terminal index for whichever phase is walking the image.
  always_comb begin
    last_value = '0;
    case (state)
      ST_DMEM_RD, ST_DMEM_WR: last_value = DMEM_LAST;
      ST_IMEM:                last_value = IMEM_LAST;
      ST_REGS:                last_value = REG_LAST;
      default:                last_value = '0;
    endcase
  end

  boot_addr_counter #(.width_p(IDX_W)) u_addr_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (idx_clear),
    .inc        (idx_inc),
    .last_value (last_value),
    .idx        (idx),
    .last       (idx_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, index control and packet issue for the packet pipeline.
  always_comb begin
    state_next  = state;
    idx_clear   = 1'b0;
    idx_inc     = 1'b0;
    issue_valid = 1'b0;
    issue_op    = NET_OP_NULL;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          idx_clear  = 1'b1;
          state_next = FIRST_STATE;
        end
      end
      ST_DMEM_RD: state_next = ST_DMEM_WR;
      ST_DMEM_WR: begin
        if (idx_last) begin
          idx_clear  = 1'b1;
          state_next = AFTER_DMEM;
        end else begin
          idx_inc    = 1'b1;
          state_next = ST_DMEM_RD;
        end
      end
      ST_IMEM: begin
        issue_valid = 1'b1;
        issue_op    = NET_OP_INSTR;
        if (idx_last) begin
          idx_clear  = 1'b1;
          state_next = AFTER_IMEM;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_REGS: begin
        issue_valid = 1'b1;
        issue_op    = NET_OP_REG;
        if (idx_last) begin
          idx_clear  = 1'b1;
          state_next = ST_BAR;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_BAR: begin
        issue_valid = 1'b1;
        issue_op    = NET_OP_BAR;
        state_next  = ST_PC;
      end
      ST_PC: begin
        issue_valid = 1'b1;
        issue_op    = NET_OP_PC;
        state_next  = ST_NULLP;
      end
      ST_NULLP: begin
        issue_valid = 1'b1;
        issue_op    = NET_OP_NULL;
        state_next  = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Issue stage: remembers which packet the ROM word arriving next cycle belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_op    <= NET_OP_NULL;
      pend_addr  <= '0;
    end else begin
      pend_valid <= issue_valid;
      pend_op    <= issue_op;
      pend_addr  <= idx;
    end
  end

  // Packet assembly from the pending tag and the ROM word now on the inputs.
  always_comb begin
    pkt_next        = '0;
    pkt_next.id     = core_id_p;
    pkt_next.net_op = pend_op;
    case (pend_op)
      NET_OP_INSTR: begin
        pkt_next.net_data = {16'b0, instr_word};
        pkt_next.net_addr = 10'(pend_addr);
      end
      NET_OP_REG: begin
        pkt_next.net_data = reg_data_i[31:0];
        pkt_next.net_addr = {4'b0, reg_data_i[37:32]};
      end
      NET_OP_BAR: begin
        pkt_next.net_data = bar_mask_p;
        pkt_next.net_addr = bar_addr_p;
      end
      NET_OP_PC: begin
        pkt_next.net_data = start_pc_p;
        pkt_next.net_addr = 10'd0;
      end
      default: begin
        pkt_next.net_data = NULL_PACKET_DATA;
        pkt_next.net_addr = bar_addr_p;
      end
    endcase
  end

  // Output packet register; holds the last packet (the NULL idle packet at the end).
  always_ff @(posedge clk) begin
    if (reset)           pkt_q <= '0;
    else if (pend_valid) pkt_q <= pkt_next;
  end

  // Completion flag rises once the NULL packet has drained onto the output.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == ST_DONE) && (state_next == ST_DONE) && !pend_valid;
  end

  assign img_addr_o        = 10'(idx);
  assign mem_valid_o       = (state == ST_DMEM_WR);
  assign mem_wen_o         = (state == ST_DMEM_WR);
  assign mem_addr_o        = (state == ST_DMEM_WR) ? 32'({idx, 2'b00}) : 32'd0;
  assign mem_wdata_o       = (state == ST_DMEM_WR) ? data_data_i : 32'd0;
  assign mem_select_o      = done_q;
  assign done_o            = done_q;
  assign busy_o            = (state != ST_IDLE) && !done_q;
  assign net_packet_flat_o = pkt_q;

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb/tb_core_boot_sequencer.sv - scoreboard bench for core_boot_sequencer
module tb_core_boot_sequencer;
  import core_boot_sequencer_pkg::*;

  localparam int PKT_W = $bits(net_packet_s);
  localparam int EV_STORE = 0;
  localparam int EV_PKT   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_BUSY  = 3;

  typedef struct packed {
    logic             mem_valid;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_select;
    logic             busy;
    logic             done;
    logic [PKT_W-1:0] pkt;
  } obs_t;

  typedef struct {
    int               dut;
    int               kind;
    int               cyc;
    logic [31:0]      addr;
    logic [31:0]      dat;
    logic [PKT_W-1:0] pkt;
    logic             busy;
  } ev_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  ev_t  exp_q[$];

  logic rst0, rst1, start0, start1;
  logic [9:0]  img0, img1;
  logic [15:0] instr_q0, instr_q1;
  logic [31:0] data_q0, data_q1;
  logic [39:0] reg_q0, reg_q1;
  logic        mv0, mw0, ms0, bz0, dn0, mv1, mw1, ms1, bz1, dn1;
  logic [31:0] ma0, md0, ma1, md1;
  logic [PKT_W-1:0] pk0, pk1;

  logic [31:0] data_rom  [4] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0001, 32'h0BAD_F00D};
  logic [15:0] instr_rom [4] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h0F0F};
  logic [39:0] reg_rom   [4] = '{{2'b11, 6'd5, 32'hCAFE_0005}, {2'b10, 6'd63, 32'h7777_0003},
                                 {2'b00, 6'd1, 32'h1}, {2'b00, 6'd2, 32'h2}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Image ROMs with one-cycle read latency, one copy per DUT.
  always @(posedge clk) begin
    instr_q0 <= instr_rom[img0[1:0]];
    data_q0  <= data_rom[img0[1:0]];
    reg_q0   <= reg_rom[img0[1:0]];
    instr_q1 <= instr_rom[img1[1:0]];
    data_q1  <= data_rom[img1[1:0]];
    reg_q1   <= reg_rom[img1[1:0]];
  end

  core_boot_sequencer #(.dmem_words_p(4), .imem_words_p(3), .reg_words_p(2)) dut0 (
    .clk(clk), .reset(rst0), .start_i(start0), .img_addr_o(img0),
    .instr_data_i(instr_q0), .data_data_i(data_q0), .reg_data_i(reg_q0),
    .mem_valid_o(mv0), .mem_wen_o(mw0), .mem_addr_o(ma0), .mem_wdata_o(md0),
    .mem_select_o(ms0), .net_packet_flat_o(pk0), .busy_o(bz0), .done_o(dn0));

  core_boot_sequencer #(.dmem_words_p(0), .imem_words_p(3), .reg_words_p(2)) dut1 (
    .clk(clk), .reset(rst1), .start_i(start1), .img_addr_o(img1),
    .instr_data_i(instr_q1), .data_data_i(data_q1), .reg_data_i(reg_q1),
    .mem_valid_o(mv1), .mem_wen_o(mw1), .mem_addr_o(ma1), .mem_wdata_o(md1),
    .mem_select_o(ms1), .net_packet_flat_o(pk1), .busy_o(bz1), .done_o(dn1));

  obs_t obs [2];
  assign obs[0] = {mv0, mw0, ma0, md0, ms0, bz0, dn0, pk0};
  assign obs[1] = {mv1, mw1, ma1, md1, ms1, bz1, dn1, pk1};

  function automatic logic [PKT_W-1:0] mk_pkt(input net_op_e op, input logic [31:0] d,
                                               input logic [9:0] a);
    net_packet_s p;
    p.id       = 10'd1;
    p.net_op   = op;
    p.reserved = 4'd0;
    p.net_data = d;
    p.net_addr = a;
    return p;
  endfunction

  task automatic push(input int d, input int k, input int c, input logic [31:0] a,
                      input logic [31:0] dat, input logic [PKT_W-1:0] p, input logic b);
    ev_t e;
    e.dut = d; e.kind = k; e.cyc = c; e.addr = a; e.dat = dat; e.pkt = p; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Expected events for a boot with nd data words, 3 instructions and 2 registers.
  task automatic push_run(input int d, input int s, input int nd, input bit full);
    int f;
    logic [39:0] r;
    f = s + 1 + 2 * nd;
    push(d, EV_BUSY, s + 1, 0, 0, '0, 1'b1);
    for (int k = 0; k < nd; k++) push(d, EV_STORE, s + 2 + 2 * k, 32'(4 * k), data_rom[k], '0, 1'b1);
    if (!full) begin
      push(d, EV_PKT, f + 2, 0, 0, mk_pkt(NET_OP_INSTR, {16'h0, instr_rom[0]}, 10'd0), 1'b1);
      return;
    end
    for (int i = 0; i < 3; i++)
      push(d, EV_PKT, f + 2 + i, 0, 0, mk_pkt(NET_OP_INSTR, {16'h0, instr_rom[i]}, 10'(i)), 1'b1);
    for (int j = 0; j < 2; j++) begin
      r = reg_rom[j];
      push(d, EV_PKT, f + 5 + j, 0, 0, mk_pkt(NET_OP_REG, r[31:0], {4'b0, r[37:32]}), 1'b1);
    end
    push(d, EV_PKT, f + 7, 0, 0, mk_pkt(NET_OP_BAR, 32'h2, 10'd24), 1'b1);
    push(d, EV_PKT, f + 8, 0, 0, mk_pkt(NET_OP_PC, 32'h0, 10'd0), 1'b1);
    push(d, EV_PKT, f + 9, 0, 0, mk_pkt(NET_OP_NULL, 32'hFFFF_FFFE, 10'd24), 1'b1);
    push(d, EV_DONE, f + 10, 0, 0, '0, 1'b0);
  endtask

  task automatic check_event(input int d, input int k);
    ev_t  e;
    logic ok;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event dut=%0d kind=%0d cyc=%0d: got event, expected none", d, k, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.dut == d) && (e.kind == k) && (e.cyc == cyc);
    case (k)
      EV_STORE: ok = ok && obs[d].mem_wen && (obs[d].mem_addr == e.addr) &&
                     (obs[d].mem_wdata == e.dat) && !obs[d].mem_select;
      EV_PKT:   ok = ok && (obs[d].pkt == e.pkt) && (obs[d].busy == e.busy);
      EV_DONE:  ok = ok && obs[d].mem_select && !obs[d].busy && !obs[d].mem_valid;
      default:  ok = ok && !obs[d].mem_select && !obs[d].done;
    endcase
    if (!ok) begin
      failures++;
      $display("FAIL event dut=%0d kind=%0d cyc=%0d addr=%h data=%h pkt=%h busy=%b sel=%b got; expected dut=%0d kind=%0d cyc=%0d addr=%h data=%h pkt=%h busy=%b",
               d, k, cyc, obs[d].mem_addr, obs[d].mem_wdata, obs[d].pkt, obs[d].busy,
               obs[d].mem_select, e.dut, e.kind, e.cyc, e.addr, e.dat, e.pkt, e.busy);
    end
  endtask

  // Monitor: every store, packet change, done rise and busy rise pops the scoreboard.
  logic [PKT_W-1:0] prev_pkt [2];
  logic             prev_done [2];
  logic             prev_busy [2];
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (obs[d].mem_valid)                  check_event(d, EV_STORE);
        if (obs[d].pkt != prev_pkt[d])         check_event(d, EV_PKT);
        if (obs[d].done && !prev_done[d])      check_event(d, EV_DONE);
        if (obs[d].busy && !prev_busy[d])      check_event(d, EV_BUSY);
      end
    end
    for (int d = 0; d < 2; d++) begin
      prev_pkt[d]  = obs[d].pkt;
      prev_done[d] = obs[d].done;
      prev_busy[d] = obs[d].busy;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int d);
    if (d == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  int s;
  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] != '0) begin
        failures++;
        $display("FAIL reset_state dut=%0d: got %h, expected all zero", d, obs[d]);
      end
    end
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Full boot; a start pulse during REGS must be ignored.
    s = cyc;
    push_run(0, s, 4, 1'b1);
    pulse_start(0);
    wait_to(s + 12);
    pulse_start(0);
    wait_to(s + 24);

    // Restart from DONE replays everything.
    s = cyc;
    push_run(0, s, 4, 1'b1);
    pulse_start(0);
    wait_to(s + 24);

    // Reset in the middle of IMEM clears the packet and busy.
    s = cyc;
    push_run(0, s, 4, 1'b0);
    push(0, EV_PKT, s + 12, 0, 0, '0, 1'b0);
    pulse_start(0);
    wait_to(s + 11);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    wait_to(s + 16);

    // After the abort, a new start replays from data word 0.
    s = cyc;
    push_run(0, s, 4, 1'b1);
    pulse_start(0);
    wait_to(s + 24);

    // No data words: first activity is INSTR 0, no stores.
    s = cyc;
    push_run(1, s, 0, 1'b1);
    pulse_start(1);
    wait_to(s + 16);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events: got %0d unobserved, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
